pueo_uram_readout_sched: RTL
============================

# pueo_uram_readout_sched

Readout scheduler for the per-channel URAM sample buffers in the memclk (500 MHz) domain. Converts trigger pulses into buffer start addresses (current write address minus a pretrigger offset, modulo buffer depth). Queues them and issues one start address at a time to all NCHAN channel buffers in lockstep. Holds off the next readout until every buffer reports completion or a timeout expires.

## Interface
Parameters:
- ADDRLEN, 14, buffer address width (depth 2^ADDRLEN words of 6 samples)
- ADDRBITS, 16, width of issued address bus; upper bits zero
- NCHAN, 8, number of channel buffers driven in lockstep
- QDEPTH, 4, pending-trigger queue depth (power of 2, ≥2)
- TIMEOUT, 4096, max memclk cycles in WAIT before abort

Ports:
- memclk  in  1  memory clock; all logic on its rising edge
- memclk_rst_i  in  1  reset, asynchronous, active-high
- enable_i  in  1  triggers accepted only while high
- clear_i  in  1  synchronous pulse; clears overflow_o and timeout_o
- trig_i  in  1  trigger pulse, one cycle per event
- write_addr_i  in  ADDRLEN  current buffer write address
- pretrig_i  in  ADDRLEN  pretrigger offset in words, sampled with trig_i
- m_axis_tdata  out  ADDRBITS  start address to all buffers
- m_axis_tvalid  out  1  start address valid
- m_axis_tready  in  NCHAN  per-buffer accept; each may be a single-cycle pulse
- done_i  in  NCHAN  per-buffer readout-complete pulse
- busy_o  out  1  high in ISSUE or WAIT
- pending_o  out  $clog2(QDEPTH)+1  queue occupancy
- overflow_o  out  1  sticky: trigger dropped on full queue
- timeout_o  out  1  sticky: readout aborted by timeout

## Operation
- Start address = (write_addr_i − pretrig_i) mod 2^ADDRLEN, computed and registered on the trig_i cycle.
- Queue write occurs only when trig_i && enable_i.
- Full queue, trig_i, no pop same cycle: event dropped, overflow_o set.
- Full queue, trig_i, pop same cycle: event accepted.
- States:
  - IDLE: queue non-empty → pop head into address register, clear ready_mask and done_mask, go ISSUE.
  - ISSUE: m_axis_tvalid=1, tdata=address. ready_mask |= m_axis_tready. When (ready_mask | m_axis_tready) is all ones → go WAIT on the next edge, drop tvalid.
  - WAIT: done_mask |= done_i. All ones → IDLE.
- Timeout:
  - Counter cleared on entering ISSUE; counts in ISSUE and WAIT.
  - Reaching TIMEOUT → timeout_o set, return IDLE; the head entry is discarded.
- done_i arriving during ISSUE is recorded in done_mask.
- enable_i low does not flush the queue or abort an in-progress readout.
- clear_i and a set event in the same cycle: set wins.
- Reset values:
  - all outputs 0
  - state IDLE
  - queue empty
  - masks and counter 0

## Timing
- trig_i at cycle n, IDLE, queue empty:
  - entry written at edge n+1
  - popped at edge n+2
  - m_axis_tvalid high from cycle n+2 (after edge n+2)
- tvalid falls the cycle after the last outstanding tready bit is seen.
- Minimum tvalid width: 1 cycle.
- Back-to-back readouts: WAIT→IDLE→ISSUE costs 2 cycles between the completing done_i and the next tvalid.
- pending_o counts entries not yet popped; it is registered and updates one edge after a push or pop.
- Address subtraction wraps without a flag. Example: write 5, pretrig 10 → 2^ADDRLEN−5.
- Async reset mid-readout returns to IDLE immediately. Buffers are not informed; the system reset resets them too.

## Structure
- Shared package pueo_uram_pkg holds:
  - ADDRLEN default
  - state enum sched_state_t {IDLE, ISSUE, WAIT}
  - helper function for start-address wrap
- One sub-module pueo_trig_fifo:
  - QDEPTH × ADDRLEN synchronous FIFO, async reset
  - push/pop/full/empty/count
  - registers only, no BRAM

## Test plan
- Single trigger, write_addr_i=1000, pretrig_i=200, all tready pulse 1 cycle after tvalid, done_i 50 cycles later → tdata=800, tvalid 1 cycle, busy_o low 1 cycle after done.
- Wrap: write_addr_i=5, pretrig_i=10, ADDRLEN=14 → tdata=16379, upper ADDRBITS bits 0.
- Staggered tready (buffer k pulses at cycle k) and staggered done_i → tvalid held until bit 7 seen; IDLE only after last done.
- Six triggers during one readout, QDEPTH=4 → pending_o saturates at 4, overflow_o=1, exactly 4 subsequent readouts; clear_i drops overflow_o.
- One buffer never asserts done_i, TIMEOUT=4096 → timeout_o=1 at cycle 4096 after entering ISSUE, next queued address issued 1 cycle later.
- memclk_rst_i asserted mid-WAIT with 2 pending → outputs all 0 asynchronously, pending_o=0, no tvalid after release until a new trig_i.

Source files
------------

// File: rtl/pueo_uram_pkg.sv
// Shared definitions for the URAM readout scheduler: default address width,
// scheduler state encoding and the start-address wrap helper.
// No ports; imported by pueo_uram_readout_sched.
package pueo_uram_pkg;

  localparam int ADDRLEN_DEFAULT = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_t;

  // (wr - pre) modulo 2^alen. Operands arrive zero-extended to 32 bits, so
  // the plain subtraction followed by masking gives the circular-buffer wrap.
  function automatic logic [31:0] start_addr(input logic [31:0] wr,
                                             input logic [31:0] pre,
                                             input int          alen);
    logic [31:0] mask;
    mask = (alen >= 32) ? 32'hFFFF_FFFF : ((32'd1 << alen) - 32'd1);
    return (wr - pre) & mask;
  endfunction

endpackage

// File: rtl/pueo_trig_fifo.sv
// Small register-based FIFO holding pending readout start addresses.
// Ports: clk/rst (async active-high), push/push_data, pop/pop_data (head,
// combinational), full, empty, count (registered occupancy).
module pueo_trig_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is allowed when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pueo_uram_readout_sched.sv
// Readout scheduler: turns trigger pulses into wrapped buffer start addresses,
// queues them and hands one at a time to all NCHAN buffers in lockstep,
// waiting for every buffer's done (or a timeout) before the next readout.
// Ports: memclk/memclk_rst_i, enable_i/clear_i/trig_i, write_addr_i/pretrig_i,
// m_axis_* (start address stream), done_i, busy_o/pending_o/overflow_o/timeout_o.
module pueo_uram_readout_sched
  import pueo_uram_pkg::*;
#(
  parameter int ADDRLEN  = ADDRLEN_DEFAULT,
  parameter int ADDRBITS = 16,
  parameter int NCHAN    = 8,
  parameter int QDEPTH   = 4,
  parameter int TIMEOUT  = 4096
) (
  input  logic                      memclk,
  input  logic                      memclk_rst_i,
  input  logic                      enable_i,
  input  logic                      clear_i,
  input  logic                      trig_i,
  input  logic [ADDRLEN-1:0]        write_addr_i,
  input  logic [ADDRLEN-1:0]        pretrig_i,
  output logic [ADDRBITS-1:0]       m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic [NCHAN-1:0]          m_axis_tready,
  input  logic [NCHAN-1:0]          done_i,
  output logic                      busy_o,
  output logic [$clog2(QDEPTH):0]   pending_o,
  output logic                      overflow_o,
  output logic                      timeout_o
);

  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [NCHAN-1:0] ALL_ONES = '1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

  sched_state_t       state;
  sched_state_t       state_nxt;
  logic [ADDRLEN-1:0] addr_q;
  logic [ADDRLEN-1:0] trig_addr;
  logic [ADDRLEN-1:0] head_addr;
  logic [NCHAN-1:0]   ready_mask;
  logic [NCHAN-1:0]   done_mask;
  logic [TW-1:0]      tmo_cnt;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               issue_done;
  logic               wait_done;
  logic               tmo_hit;
  logic               tmo_evt;
  logic               drop_evt;

  assign trig_addr = ADDRLEN'(start_addr(32'(write_addr_i), 32'(pretrig_i), ADDRLEN));

  // Including this cycle's inputs lets a buffer's single-cycle pulse finish
  // the phase on the same edge that records it.
  assign issue_done = ((ready_mask | m_axis_tready) == ALL_ONES);
  assign wait_done  = ((done_mask | done_i) == ALL_ONES);
  assign tmo_hit    = (tmo_cnt == TMO_LAST);

  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign fifo_push = trig_i && enable_i;
  assign drop_evt  = fifo_push && fifo_full && !fifo_pop;

  // In ISSUE the timeout wins over acceptance; in WAIT a completion arriving
  // on the final cycle wins over the abort.
  assign tmo_evt = tmo_hit && ((state == ISSUE) || ((state == WAIT) && !wait_done));

  pueo_trig_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (ADDRLEN)
  ) u_fifo (
    .clk       (memclk),
    .rst       (memclk_rst_i),
    .push      (fifo_push),
    .push_data (trig_addr),
    .pop       (fifo_pop),
    .pop_data  (head_addr),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (pending_o)
  );

  // State register
  always_ff @(posedge memclk or posedge memclk_rst_i) begin
    if (memclk_rst_i) state <= IDLE;
    else              state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fifo_pop) state_nxt = ISSUE;
      ISSUE: begin
        if (tmo_hit)         state_nxt = IDLE;
        else if (issue_done) state_nxt = WAIT;
      end
      WAIT:    if (wait_done || tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    m_axis_tvalid = (state == ISSUE);
    busy_o        = (state != IDLE);
    m_axis_tdata  = (state == ISSUE) ? ADDRBITS'(addr_q) : '0;
  end

  // Readout datapath: current address, acceptance/completion masks, timeout
  // counter and the sticky status flags.
  always_ff @(posedge memclk or posedge memclk_rst_i) begin
    if (memclk_rst_i) begin
      addr_q     <= '0;
      ready_mask <= '0;
      done_mask  <= '0;
      tmo_cnt    <= '0;
      overflow_o <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      if (fifo_pop) begin
        addr_q     <= head_addr;
        ready_mask <= '0;
        done_mask  <= '0;
        tmo_cnt    <= '0;
      end else if (state == ISSUE) begin
        ready_mask <= ready_mask | m_axis_tready;
        done_mask  <= done_mask | done_i;
        tmo_cnt    <= tmo_cnt + 1'b1;
      end else if (state == WAIT) begin
        done_mask  <= done_mask | done_i;
        tmo_cnt    <= tmo_cnt + 1'b1;
      end

      if (drop_evt)     overflow_o <= 1'b1;
      else if (clear_i) overflow_o <= 1'b0;

      if (tmo_evt)      timeout_o  <= 1'b1;
      else if (clear_i) timeout_o  <= 1'b0;
    end
  end

endmodule
